// File: rtl/upe_sqrt64u.sv
// upe_sqrt64u: sequential unsigned 64-bit integer square root.
// Converts a propagated variance back into a 32-bit standard deviation using
// the restoring digit-by-digit method, one root bit per clock.
// Optional build macro UPE_SQRT_ROUND_EN: round the root to nearest, saturating
// at 0xFFFFFFFF. The floor remainder is reported in both builds.
module upe_sqrt64u (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] In,
  input  logic        start,
  output logic        ready,
  output logic [31:0] Out,
  output logic [32:0] Rem,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] op_q, op_d;      // radicand, consumed two bits per iteration from the top
  logic [31:0] root_q, root_d;  // partial root
  logic [33:0] rem_q, rem_d;    // partial remainder, bounded by 2*root+1
  logic [4:0]  cnt_q, cnt_d;    // iterations left; zero marks the last one
  logic [31:0] out_q, out_d;
  logic [32:0] remo_q, remo_d;
  logic        valid_q, valid_d;

  logic [33:0] rem_sh;
  logic [33:0] trial;

`ifdef UPE_SQRT_ROUND_EN
  // Round to nearest: x > r^2 + r exactly when sqrt(x) > r + 0.5.
  function automatic logic [31:0] round_root(input logic [31:0] r,
                                             input logic [33:0] rm);
    if ((rm > {2'b00, r}) && (r != 32'hFFFF_FFFF)) return r + 32'd1;
    return r;
  endfunction
`endif

  // Next-state, datapath iteration and result capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    root_d  = root_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    remo_d  = remo_q;
    valid_d = 1'b0;
    // The shifted remainder always fits in 34 bits because the previous
    // remainder is at most 2*root < 2^32; the cast only drops zero bits.
    rem_sh  = 34'((36'(rem_q) << 2) | 36'(op_q[63:62]));
    trial   = {root_q, 2'b01};
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = In;
          root_d  = '0;
          rem_d   = '0;
          cnt_d   = 5'd31;
          state_d = CALC;
        end
      end
      CALC: begin
        op_d = op_q << 2;
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = DONE;
      end
      DONE: begin
`ifdef UPE_SQRT_ROUND_EN
        out_d = round_root(root_q, rem_q);
`else
        out_d = root_q;
`endif
        remo_d  = rem_q[32:0];
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      remo_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      remo_q  <= remo_d;
      valid_q <= valid_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign Out   = out_q;
  assign Rem   = remo_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_upe_sqrt64u.sv
// Directed bench for upe_sqrt64u: reset state, hand-computed roots, latency,
// back-to-back starts, ignored busy starts, reset abort and a random sweep.
module tb_upe_sqrt64u;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] In;
  logic        start;
  logic        ready;
  logic [31:0] Out;
  logic [32:0] Rem;
  logic        valid;

  int checks   = 0;
  int failures = 0;

  upe_sqrt64u dut (
    .clk   (clk),
    .rst   (rst),
    .In    (In),
    .start (start),
    .ready (ready),
    .Out   (Out),
    .Rem   (Rem),
    .valid (valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one conversion from a negedge and return when valid is seen (or the bound expires).
  task automatic do_conv(input logic [63:0] x, output logic [31:0] o, output logic [32:0] r,
                         output int lat, output int lowc);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    In    = x;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    In    = {$urandom, $urandom};
    lat   = 1;
    lowc  = 0;
    while (valid !== 1'b1 && lat < 100) begin
      if (ready === 1'b0) lowc++;
      @(negedge clk);
      lat++;
    end
    o = Out;
    r = Rem;
  endtask

  task automatic run(input string tag, input logic [63:0] x, input logic [31:0] eo,
                     input logic [32:0] er);
    logic [31:0] o;
    logic [32:0] r;
    int lat, lowc;
    do_conv(x, o, r, lat, lowc);
    chk({tag, "_lat"}, 64'(lat), 64'd34);
    chk({tag, "_out"}, 64'(o), 64'(eo));
    chk({tag, "_rem"}, 64'(r), 64'(er));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(valid), 64'd0);
  endtask

  initial begin
    logic [31:0] o;
    logic [32:0] r;
    int lat, lowc, nv, v1, v2;
    logic [63:0] x;
    logic [31:0] f;
    logic [127:0] sq, sq1;

    rst   = 1'b1;
    start = 1'b0;
    In    = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_out",   64'(Out),   64'd0);
    chk("rst_rem",   64'(Rem),   64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero operand with full latency and ready-low window
    do_conv(64'd0, o, r, lat, lowc);
    chk("zero_lat",   64'(lat),  64'd34);
    chk("zero_ready", 64'(lowc), 64'd33);
    chk("zero_out",   64'(o),    64'd0);
    chk("zero_rem",   64'(r),    64'd0);
    @(negedge clk);
    chk("zero_pulse", 64'(valid), 64'd0);

    run("sq144", 64'd144, 32'd12, 33'd0);
`ifdef UPE_SQRT_ROUND_EN
    run("n157", 64'd157, 32'd13, 33'd13);
`else
    run("n157", 64'd157, 32'd12, 33'd13);
`endif
    run("n156", 64'd156, 32'd12, 33'd12);
    run("max",  64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);

    // Start pulses while busy must not produce or queue another result
    In    = 64'd625;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nv = 0;
    for (int i = 2; i <= 60; i++) begin
      start = (i <= 30) && (i % 5 == 0);
      @(negedge clk);
      if (valid === 1'b1) begin
        nv++;
        chk("busy_out", 64'(Out), 64'd25);
        chk("busy_rem", 64'(Rem), 64'd0);
      end
    end
    start = 1'b0;
    chk("busy_nvalid", 64'(nv), 64'd1);
    chk("busy_idle",   64'(ready), 64'd1);

    // Start held high: results 34 cycles apart
    In    = 64'h4000_0000_0000_0000;
    start = 1'b1;
    nv = 0; v1 = 0; v2 = 0;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        nv++;
        if (nv == 1) v1 = i;
        if (nv == 2) v2 = i;
        chk("b2b_out", 64'(Out), 64'h8000_0000);
        chk("b2b_rem", 64'(Rem), 64'd0);
      end
    end
    start = 1'b0;
    chk("b2b_nvalid", 64'(nv), 64'd2);
    chk("b2b_gap",    64'(v2 - v1), 64'd34);
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid === 1'b1) nv++;
    end
    chk("b2b_drain", 64'(nv), 64'd1);

    // Reset in the middle of CALC aborts at once
    In    = 64'd1000000000000;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_valid", 64'(valid), 64'd0);
    chk("abort_out",   64'(Out),   64'd0);
    chk("abort_rem",   64'(Rem),   64'd0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid === 1'b1) nv++;
    end
    chk("abort_novalid", 64'(nv), 64'd0);
    run("restart", 64'd1000000000000, 32'd1000000, 33'd0);

    // Random sweep checked against the defining inequalities
    for (int k = 0; k < 1000; k++) begin
      x = {$urandom, $urandom} >> $urandom_range(0, 63);
      do_conv(x, o, r, lat, lowc);
      chk("sweep_lat", 64'(lat), 64'd34);
      sq = {96'd0, o} * {96'd0, o};
`ifdef UPE_SQRT_ROUND_EN
      f = (sq > {64'd0, x}) ? o - 32'd1 : o;
      chk("sweep_round", 64'(o),
          64'(((r > {1'b0, f}) && (f != 32'hFFFF_FFFF)) ? f + 32'd1 : f));
`else
      f = o;
`endif
      sq  = {96'd0, f} * {96'd0, f};
      sq1 = ({96'd0, f} + 128'd1) * ({96'd0, f} + 128'd1);
      chk("sweep_bounds", 64'((sq <= {64'd0, x}) && ({64'd0, x} < sq1)), 64'd1);
      chk("sweep_rem", 64'(r), x - sq[63:0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
